// File: rtl/dispensador_multilinha.sv
// Purpose: one shared cork reservoir feeding N_LINHAS line counters, with round-robin timed refills,
//          per-line manual +1 adds and a valid/ready reservoir replenish port.
// Latency: need seen at edge k -> line count updated at edge k+TEMPO_TRANSF+1; manual add and decrement 1 cycle.
// Backpressure: REPOR_READY is high only while idle (OCIOSO); offers during a transfer wait until idle.
//
// Ports:
//   CLOCK, RESET_N                 rising-edge clock, asynchronous active-low reset
//   DECREMENTA[N]                  1-cycle pulse per line, one cork consumed
//   ADICIONA_MANUAL[N]             raw level per line, rising edge requests +1
//   REPOR_VALID/REPOR_QTD/READY    reservoir replenish handshake
//   COUNT_ROLHAS                   line i at [i*W_CONT +: W_CONT]
//   ESTOQUE_DISP                   reservoir stock
//   ROLHAS_DISPONIVEIS/ALARME_SEM_ROLHA  per-line status flags
//   DISPENSADOR_ATIVO/LINHA_ATIVA  transfer in progress and the line being served
module dispensador_multilinha #(
  parameter int N_LINHAS         = 2,
  parameter int W_CONT           = 7,
  parameter int W_ESTOQUE        = 8,
  parameter int CAPACIDADE       = 150,
  parameter int QTD_RECARGA      = 15,
  parameter int LIMITE_MIN       = 5,
  parameter int LIMITE_MAX       = 99,
  parameter int TEMPO_TRANSF     = 4,
  parameter int CONTAGEM_INICIAL = 0
) (
  input  logic                                           CLOCK,
  input  logic                                           RESET_N,
  input  logic [N_LINHAS-1:0]                            DECREMENTA,
  input  logic [N_LINHAS-1:0]                            ADICIONA_MANUAL,
  input  logic                                           REPOR_VALID,
  input  logic [W_ESTOQUE-1:0]                           REPOR_QTD,
  output logic                                           REPOR_READY,
  output logic [N_LINHAS*W_CONT-1:0]                     COUNT_ROLHAS,
  output logic [W_ESTOQUE-1:0]                           ESTOQUE_DISP,
  output logic [N_LINHAS-1:0]                            ROLHAS_DISPONIVEIS,
  output logic [N_LINHAS-1:0]                            ALARME_SEM_ROLHA,
  output logic                                           DISPENSADOR_ATIVO,
  output logic [((N_LINHAS > 1) ? $clog2(N_LINHAS) : 1)-1:0] LINHA_ATIVA
);

  localparam int W_LINHA = (N_LINHAS > 1) ? $clog2(N_LINHAS) : 1;
  localparam int W_TIMER = (TEMPO_TRANSF > 1) ? $clog2(TEMPO_TRANSF) : 1;
  localparam int W_SOMA  = ((W_CONT > W_ESTOQUE) ? W_CONT : W_ESTOQUE) + 2;

  typedef enum logic [1:0] {OCIOSO, TRANSFERINDO, CONCLUI} estado_t;

  estado_t              estado;
  logic [W_CONT-1:0]    cont [N_LINHAS];
  logic [W_ESTOQUE-1:0] estoque;
  logic [W_LINHA-1:0]   ponteiro;
  logic [W_LINHA-1:0]   linha_g;
  logic [W_TIMER-1:0]   timer;
  logic [N_LINHAS-1:0]  manual_ant;

  logic [N_LINHAS-1:0]  need;
  logic [N_LINHAS-1:0]  dec_ef;
  logic [N_LINHAS-1:0]  borda;
  logic                 tem_manual;
  logic [W_LINHA-1:0]   idx_manual;
  logic                 manual_ok;
  logic                 tem_need;
  logic [W_LINHA-1:0]   idx_grant;
  logic [W_SOMA-1:0]    base;
  logic [W_SOMA-1:0]    lote;
  logic [W_SOMA-1:0]    soma;
  logic [W_SOMA-1:0]    novo;
  logic [W_SOMA-1:0]    deduz;
  logic [W_ESTOQUE:0]   soma_repor;
  logic [W_ESTOQUE-1:0] estoque_repor;

  assign borda = ADICIONA_MANUAL & ~manual_ant;

  always_comb begin
    need       = '0;
    dec_ef     = '0;
    tem_manual = 1'b0;
    idx_manual = '0;
    tem_need   = 1'b0;
    idx_grant  = '0;
    for (int i = 0; i < N_LINHAS; i++) begin
      need[i]   = (int'(cont[i]) <= LIMITE_MIN) && (int'(cont[i]) < LIMITE_MAX);
      dec_ef[i] = DECREMENTA[i] && (cont[i] != '0);
    end
    // Scan downwards so the lowest index (manual) / nearest-after-pointer (grant) wins.
    for (int i = N_LINHAS-1; i >= 0; i--) begin
      if (borda[i]) begin
        tem_manual = 1'b1;
        idx_manual = W_LINHA'(i);
      end
    end
    for (int k = N_LINHAS-1; k >= 0; k--) begin
      if (need[(int'(ponteiro) + k) % N_LINHAS]) begin
        tem_need  = 1'b1;
        idx_grant = W_LINHA'((int'(ponteiro) + k) % N_LINHAS);
      end
    end
  end

  assign manual_ok = (estado == OCIOSO) && tem_manual &&
                     (int'(cont[int'(idx_manual)]) < LIMITE_MAX) && (estoque != '0);

  // Transfer completion: a decrement on the served line this cycle lowers the base first.
  always_comb begin
    base  = W_SOMA'(cont[int'(linha_g)]) - W_SOMA'(dec_ef[int'(linha_g)]);
    lote  = (W_SOMA'(estoque) < W_SOMA'(QTD_RECARGA)) ? W_SOMA'(estoque) : W_SOMA'(QTD_RECARGA);
    soma  = base + lote;
    novo  = (soma > W_SOMA'(LIMITE_MAX)) ? W_SOMA'(LIMITE_MAX) : soma;
    deduz = novo - base;
  end

  // Replenish sum is one bit wider so a large offer cannot wrap before saturation.
  always_comb begin
    soma_repor    = {1'b0, estoque} + {1'b0, REPOR_QTD} - (W_ESTOQUE+1)'(manual_ok);
    estoque_repor = (int'(soma_repor) > CAPACIDADE) ? W_ESTOQUE'(CAPACIDADE)
                                                    : soma_repor[W_ESTOQUE-1:0];
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado     <= OCIOSO;
      for (int i = 0; i < N_LINHAS; i++) cont[i] <= W_CONT'(CONTAGEM_INICIAL);
      estoque    <= W_ESTOQUE'(CAPACIDADE);
      ponteiro   <= '0;
      linha_g    <= '0;
      timer      <= '0;
      manual_ant <= '0;
    end else begin
      manual_ant <= ADICIONA_MANUAL;
      for (int i = 0; i < N_LINHAS; i++) begin
        if (dec_ef[i]) cont[i] <= cont[i] - 1'b1;
      end
      case (estado)
        OCIOSO: begin
          if (manual_ok) begin
            // Add and consume on the same line cancel; the cork still leaves the reservoir.
            cont[int'(idx_manual)] <= dec_ef[int'(idx_manual)] ? cont[int'(idx_manual)]
                                                               : cont[int'(idx_manual)] + 1'b1;
          end
          if (REPOR_VALID)    estoque <= estoque_repor;
          else if (manual_ok) estoque <= estoque - 1'b1;
          if (tem_need && (estoque != '0) && !manual_ok) begin
            estado  <= TRANSFERINDO;
            timer   <= W_TIMER'(TEMPO_TRANSF - 1);
            linha_g <= idx_grant;
          end
        end
        TRANSFERINDO: begin
          if (timer == '0) estado <= CONCLUI;
          else             timer  <= timer - 1'b1;
        end
        CONCLUI: begin
          cont[int'(linha_g)] <= W_CONT'(novo);
          estoque             <= estoque - W_ESTOQUE'(deduz);
          ponteiro            <= W_LINHA'((int'(linha_g) + 1) % N_LINHAS);
          linha_g             <= '0;
          estado              <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_LINHAS; i++) begin
      COUNT_ROLHAS[i*W_CONT +: W_CONT] = cont[i];
      ROLHAS_DISPONIVEIS[i]            = (cont[i] != '0);
      ALARME_SEM_ROLHA[i]              = (cont[i] == '0) && (estoque == '0);
    end
  end

  assign ESTOQUE_DISP      = estoque;
  assign REPOR_READY       = (estado == OCIOSO);
  assign DISPENSADOR_ATIVO = (estado != OCIOSO);
  assign LINHA_ATIVA       = linha_g;

endmodule

// File: tb/tb_dispensador_multilinha.sv
module tb_dispensador_multilinha;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic rst_a_n, rst_b_n, rst_c_n;

  // a: default parameters
  logic [1:0]  dec_a, add_a, disp_a, alm_a;
  logic        rv_a, rr_a, atv_a;
  logic [7:0]  rq_a, est_a;
  logic [13:0] cnt_a;
  logic [0:0]  lin_a;
  // b: small reservoir, lines start needy
  logic [1:0]  dec_b, add_b, disp_b, alm_b;
  logic        rv_b, rr_b, atv_b;
  logic [7:0]  rq_b, est_b;
  logic [13:0] cnt_b;
  logic [0:0]  lin_b;
  // c: single line starting near the saturation value
  logic [0:0]  dec_c, add_c, disp_c, alm_c;
  logic        rv_c, rr_c, atv_c;
  logic [7:0]  rq_c, est_c;
  logic [6:0]  cnt_c;
  logic [0:0]  lin_c;

  dispensador_multilinha dut_a (
    .CLOCK(CLOCK), .RESET_N(rst_a_n), .DECREMENTA(dec_a), .ADICIONA_MANUAL(add_a),
    .REPOR_VALID(rv_a), .REPOR_QTD(rq_a), .REPOR_READY(rr_a), .COUNT_ROLHAS(cnt_a),
    .ESTOQUE_DISP(est_a), .ROLHAS_DISPONIVEIS(disp_a), .ALARME_SEM_ROLHA(alm_a),
    .DISPENSADOR_ATIVO(atv_a), .LINHA_ATIVA(lin_a));

  dispensador_multilinha #(.CAPACIDADE(7), .CONTAGEM_INICIAL(2)) dut_b (
    .CLOCK(CLOCK), .RESET_N(rst_b_n), .DECREMENTA(dec_b), .ADICIONA_MANUAL(add_b),
    .REPOR_VALID(rv_b), .REPOR_QTD(rq_b), .REPOR_READY(rr_b), .COUNT_ROLHAS(cnt_b),
    .ESTOQUE_DISP(est_b), .ROLHAS_DISPONIVEIS(disp_b), .ALARME_SEM_ROLHA(alm_b),
    .DISPENSADOR_ATIVO(atv_b), .LINHA_ATIVA(lin_b));

  dispensador_multilinha #(.N_LINHAS(1), .LIMITE_MIN(95), .CONTAGEM_INICIAL(94)) dut_c (
    .CLOCK(CLOCK), .RESET_N(rst_c_n), .DECREMENTA(dec_c), .ADICIONA_MANUAL(add_c),
    .REPOR_VALID(rv_c), .REPOR_QTD(rq_c), .REPOR_READY(rr_c), .COUNT_ROLHAS(cnt_c),
    .ESTOQUE_DISP(est_c), .ROLHAS_DISPONIVEIS(disp_c), .ALARME_SEM_ROLHA(alm_c),
    .DISPENSADOR_ATIVO(atv_c), .LINHA_ATIVA(lin_c));

  typedef struct {
    int which;
    int line;
    int count;
    int est;
  } exp_t;

  exp_t sb[$];
  int   ntot  = 0;
  int   npass = 0;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] cnt_of(input int which, input int ln);
    case (which)
      0:       cnt_of = 32'(cnt_a[ln*7 +: 7]);
      1:       cnt_of = 32'(cnt_b[ln*7 +: 7]);
      default: cnt_of = 32'(cnt_c);
    endcase
  endfunction

  function automatic logic [31:0] est_of(input int which);
    case (which)
      0:       est_of = 32'(est_a);
      1:       est_of = 32'(est_b);
      default: est_of = 32'(est_c);
    endcase
  endfunction

  function automatic logic atv_of(input int which);
    case (which)
      0:       atv_of = atv_a;
      1:       atv_of = atv_b;
      default: atv_of = atv_c;
    endcase
  endfunction

  function automatic logic [31:0] lin_of(input int which);
    case (which)
      0:       lin_of = 32'(lin_a);
      1:       lin_of = 32'(lin_b);
      default: lin_of = 32'(lin_c);
    endcase
  endfunction

  // Pop the oldest expected transfer result and compare against the DUT now.
  task automatic sb_check();
    exp_t e;
    e = sb.pop_front();
    chk($sformatf("sb_cnt_d%0d_l%0d", e.which, e.line), cnt_of(e.which, e.line), e.count);
    chk($sformatf("sb_est_d%0d", e.which), est_of(e.which), e.est);
  endtask

  // Wait for a transfer to start and finish, bounded by a cycle budget.
  task automatic wait_done(input int which, input int budget, output int hi, output int ln);
    int n;
    bit seen;
    n = 0; seen = 1'b0; hi = 0; ln = -1;
    while (n < budget) begin
      tick();
      n++;
      if (atv_of(which)) begin
        seen = 1'b1;
        hi++;
        ln = int'(lin_of(which));
      end else if (seen) begin
        break;
      end
    end
    chk($sformatf("xfer_seen_d%0d", which), 32'(seen), 1);
    chk($sformatf("xfer_idle_d%0d", which), 32'(atv_of(which)), 0);
    sb_check();
  endtask

  task automatic pulse_dec(input int which, input int mask, input int n);
    for (int k = 0; k < n; k++) begin
      case (which)
        0:       dec_a = 2'(mask);
        1:       dec_b = 2'(mask);
        default: dec_c = 1'(mask);
      endcase
      tick();
    end
    dec_a = '0; dec_b = '0; dec_c = '0;
  endtask

  initial begin
    int hi, ln;
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    dec_a = '0; add_a = '0; rv_a = 1'b0; rq_a = '0;
    dec_b = '0; add_b = '0; rv_b = 1'b0; rq_b = '0;
    dec_c = '0; add_c = '0; rv_c = 1'b0; rq_c = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_cnt0", cnt_of(0, 0), 0);
    chk("rst_cnt1", cnt_of(0, 1), 0);
    chk("rst_est", est_of(0), 150);
    chk("rst_ativo", 32'(atv_a), 0);
    chk("rst_linha", lin_of(0), 0);
    chk("rst_ready", 32'(rr_a), 1);
    chk("rst_disp", 32'(disp_a), 0);
    chk("rst_alarme", 32'(alm_a), 0);

    // Both lines empty: line0 first, then line1 by round robin
    rst_a_n = 1'b1;
    sb.push_back('{0, 0, 15, 135});
    wait_done(0, 20, hi, ln);
    chk("t1_hi_cycles", 32'(hi), 5);
    chk("t1_linha", 32'(ln), 0);
    sb.push_back('{0, 1, 15, 120});
    wait_done(0, 20, hi, ln);
    chk("t1b_linha", 32'(ln), 1);
    chk("t1b_cnt0", cnt_of(0, 0), 15);

    // Line0 alone reaches the threshold; pointer then moves to 1
    pulse_dec(0, 1, 10);
    chk("t2_cnt0_thresh", cnt_of(0, 0), 5);
    sb.push_back('{0, 0, 20, 105});
    wait_done(0, 20, hi, ln);
    // Both needy on the same edge with pointer=1: line1 first
    pulse_dec(0, 1, 5);
    pulse_dec(0, 3, 10);
    sb.push_back('{0, 1, 20, 90});
    wait_done(0, 20, hi, ln);
    chk("t2_linha", 32'(ln), 1);
    chk("t2_hi_cycles", 32'(hi), 5);
    chk("t2_cnt0_waiting", cnt_of(0, 0), 5);
    sb.push_back('{0, 0, 20, 75});
    wait_done(0, 20, hi, ln);
    chk("t2b_linha", 32'(ln), 0);

    // Replenish: plain add, then saturation at capacity
    chk("t5_ready_idle", 32'(rr_a), 1);
    rv_a = 1'b1; rq_a = 8'd25; tick(); rv_a = 1'b0;
    chk("t5_est_add", est_of(0), 100);
    rv_a = 1'b1; rq_a = 8'd200; tick(); rv_a = 1'b0;
    chk("t5_est_sat", est_of(0), 150);
    // Offer held during a transfer is only taken once idle again
    pulse_dec(0, 1, 15);
    tick();
    chk("t5_grant", 32'(atv_a), 1);
    rv_a = 1'b1; rq_a = 8'd10;
    tick();
    chk("t5_ready_busy", 32'(rr_a), 0);
    chk("t5_est_hold", est_of(0), 150);
    sb.push_back('{0, 0, 20, 135});
    wait_done(0, 20, hi, ln);
    tick(); rv_a = 1'b0;
    chk("t5_est_late_accept", est_of(0), 145);

    // Manual edges on both lines at once: only line0 is served
    add_a = 2'b11; tick();
    chk("t6_man_cnt0", cnt_of(0, 0), 21);
    chk("t6_man_cnt1", cnt_of(0, 1), 20);
    chk("t6_man_est", est_of(0), 144);
    tick();
    chk("t6_level_no_edge", cnt_of(0, 0), 21);
    add_a = 2'b00; tick();
    // Manual add together with a decrement on the same line
    add_a = 2'b01; dec_a = 2'b01; tick(); add_a = '0; dec_a = '0;
    chk("t6_man_dec_cnt", cnt_of(0, 0), 21);
    chk("t6_man_dec_est", est_of(0), 143);
    // Manual edge during a transfer is dropped; reset mid-transfer aborts it
    pulse_dec(0, 2, 15);
    tick();
    chk("t6_busy_linha", lin_of(0), 1);
    add_a = 2'b01; tick(); add_a = '0;
    chk("t6_man_busy_cnt", cnt_of(0, 0), 21);
    chk("t6_man_busy_est", est_of(0), 143);
    rst_a_n = 1'b0; #1;
    chk("t6_rst_cnt0", cnt_of(0, 0), 0);
    chk("t6_rst_cnt1", cnt_of(0, 1), 0);
    chk("t6_rst_est", est_of(0), 150);
    chk("t6_rst_ativo", 32'(atv_a), 0);
    chk("t6_rst_linha", lin_of(0), 0);

    // Small reservoir: transfer limited by stock, then empty alarm
    rst_b_n = 1'b1;
    sb.push_back('{1, 0, 9, 0});
    wait_done(1, 20, hi, ln);
    repeat (3) tick();
    chk("t3_no_grant_empty", 32'(atv_b), 0);
    chk("t3_cnt1", cnt_of(1, 1), 2);
    chk("t3_disp", 32'(disp_b), 3);
    pulse_dec(1, 1, 9);
    chk("t3_cnt0_zero", cnt_of(1, 0), 0);
    chk("t3_alarme", 32'(alm_b), 1);
    chk("t3_disp_after", 32'(disp_b), 2);
    pulse_dec(1, 1, 1);
    chk("t3_dec_at_zero", cnt_of(1, 0), 0);
    add_b = 2'b01; tick(); add_b = '0;
    chk("t3_man_no_stock", cnt_of(1, 0), 0);
    chk("t3_est_zero", est_of(1), 0);

    // Saturation at LIMITE_MAX with a decrement in the completion cycle
    rst_c_n = 1'b1;
    tick();
    chk("t4_grant", 32'(atv_c), 1);
    sb.push_back('{2, 0, 99, 144});
    repeat (4) tick();
    chk("t4_concl", 32'(atv_c), 1);
    dec_c = 1'b1; tick(); dec_c = 1'b0;
    sb_check();
    chk("t4_idle", 32'(atv_c), 0);
    repeat (2) tick();
    chk("t4_no_regrant", 32'(atv_c), 0);
    chk("t4_cnt_hold", cnt_of(2, 0), 99);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
